// File: rtl/gpu_mem_arbiter.sv
// N-channel round-robin arbiter onto a single external memory port, with
// in-order channel-ID tracking so each downstream response returns to its issuer.
package constants_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
endpackage

module gpu_mem_arbiter #(
  parameter int NUM_CHANNELS    = 4,
  parameter int ADDR_WIDTH      = constants_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH      = constants_pkg::DATA_WIDTH,
  parameter int MAX_OUTSTANDING = 4,
  localparam int CH = $clog2(NUM_CHANNELS),
  localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_CHANNELS-1:0]            c_req_vld,
  output logic [NUM_CHANNELS-1:0]            c_req_rdy,
  input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] c_req_addr,
  output logic [NUM_CHANNELS-1:0]            c_rsp_vld,
  input  logic [NUM_CHANNELS-1:0]            c_rsp_rdy,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] c_rsp_data,
  output logic                               m_req_vld,
  input  logic                               m_req_rdy,
  output logic [ADDR_WIDTH-1:0]              m_req_addr,
  input  logic                               m_rsp_vld,
  output logic                               m_rsp_rdy,
  input  logic [DATA_WIDTH-1:0]              m_rsp_data,
  output logic [OW-1:0]                      outstanding,
  output logic                               err_orphan_rsp
);

  localparam int PW = $clog2(MAX_OUTSTANDING);

  logic                  slot_vld;
  logic [ADDR_WIDTH-1:0] slot_addr;
  logic [CH-1:0]         rr_ptr;
  logic [CH-1:0]         grant;
  logic [CH-1:0]         rr_next;
  logic                  req_found;
  logic                  can_accept;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic [CH-1:0]         id_fifo [MAX_OUTSTANDING];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [OW-1:0]         count;
  logic [CH-1:0]         head;

  assign fifo_full  = (count == OW'(MAX_OUTSTANDING));
  assign fifo_empty = (count == '0);
  assign can_accept = !slot_vld || m_req_rdy;
  assign head       = id_fifo[rd_ptr];

  // Search starts at rr_ptr so the last granted channel drops to lowest priority.
  always_comb begin
    req_found = 1'b0;
    grant     = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (!req_found && c_req_vld[(int'(rr_ptr) + k) % NUM_CHANNELS]) begin
        req_found = 1'b1;
        grant     = CH'((int'(rr_ptr) + k) % NUM_CHANNELS);
      end
    end
  end

  assign rr_next = (grant == CH'(NUM_CHANNELS - 1)) ? '0 : grant + 1'b1;
  assign push    = rst_n && req_found && can_accept && !fifo_full;

  always_comb begin
    c_req_rdy = '0;
    if (push) c_req_rdy[grant] = 1'b1;
  end

  // Responses follow the FIFO head; full FIFO blocks pushes even if popping now.
  always_comb begin
    c_rsp_vld = '0;
    m_rsp_rdy = 1'b0;
    if (rst_n && !fifo_empty) begin
      c_rsp_vld[head] = m_rsp_vld;
      m_rsp_rdy       = c_rsp_rdy[head];
    end
  end

  assign pop         = m_rsp_vld && m_rsp_rdy;
  assign c_rsp_data  = {NUM_CHANNELS{m_rsp_data}};
  assign m_req_vld   = slot_vld;
  assign m_req_addr  = slot_addr;
  assign outstanding = count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_vld       <= 1'b0;
      slot_addr      <= '0;
      rr_ptr         <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      err_orphan_rsp <= 1'b0;
    end else begin
      if (push) begin
        slot_vld  <= 1'b1;
        slot_addr <= c_req_addr[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
        rr_ptr    <= rr_next;
        wr_ptr    <= wr_ptr + 1'b1;
      end else if (m_req_rdy) begin
        slot_vld <= 1'b0;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (m_rsp_vld && fifo_empty) err_orphan_rsp <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) id_fifo[wr_ptr] <= grant;
  end

endmodule
